stream_demux_1x2: RTL and testbench

//  Registered 1-to-2 stream demultiplexer: routes one valid/ready data stream to one of two

---
 rtl/stream_demux_1x2_if.sv | 33 +++
 rtl/stream_demux_1x2.sv | 146 ++++++++++++++
 tb/tb_stream_demux_1x2.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1x2_if.sv
// ============================================================================
// stream_demux_1x2_if : input stream plus two output streams of the 1:2 demux
// Rev 1.0
// ============================================================================
`default_nettype none

interface stream_demux_1x2_if #(
  parameter int In_d_W = 8
);
  logic              s_valid;
  logic [In_d_W-1:0] s_data;
  logic              s_ready;
  logic              m0_valid;
  logic [In_d_W-1:0] m0_data;
  logic              m0_ready;
  logic              m1_valid;
  logic [In_d_W-1:0] m1_data;
  logic              m1_ready;

  // master: the demultiplexer side
  modport master (
    input  s_valid, s_data, m0_ready, m1_ready,
    output s_ready, m0_valid, m0_data, m1_valid, m1_data
  );

  // slave: producer and both consumers
  modport slave (
    output s_valid, s_data, m0_ready, m1_ready,
    input  s_ready, m0_valid, m0_data, m1_valid, m1_data
  );
endinterface

`default_nettype wire

// File: rtl/stream_demux_1x2.sv
// ============================================================================
// stream_demux_1x2 : registered 1:2 stream demux, route fixed per burst.
// Optional per-branch beat counters under macro DEMUX_STATS_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module stream_demux_1x2 #(
  parameter int In_d_W    = 8,
`ifdef DEMUX_STATS_EN
  parameter int CNT_W     = 16,
`endif
  parameter int BURST_LEN = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              mode,
  input  wire logic              Sel,
  stream_demux_1x2_if.master     bus,
`ifdef DEMUX_STATS_EN
  input  wire logic              stats_clr,
  output logic [CNT_W-1:0]       cnt0,
  output logic [CNT_W-1:0]       cnt1,
`endif
  output logic                   cur_sel,
  output logic                   burst_done
);

  localparam int CNT_BW = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_BW-1:0] c_LAST = CNT_BW'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_BW-1:0]   r_cnt, w_cnt_nxt;
  logic                r_cur_sel, w_sel_nxt;
  logic                r_mode, w_mode_nxt;
  logic                r_done;
  logic                r_m0_valid, r_m1_valid;
  logic [In_d_W-1:0]   r_m0_data, r_m1_data;

  logic                w_route;
  logic                w_burst_mode;
  logic                w_acc;
  logic                w_last;

  // Route and mode are only sampled from the pins while idle; a burst keeps both.
  assign w_route      = (r_state == S_IDLE && !mode) ? Sel : r_cur_sel;
  assign w_burst_mode = (r_state == S_IDLE) ? mode : r_mode;
  assign bus.s_ready  = w_route ? (~r_m1_valid | bus.m1_ready)
                                : (~r_m0_valid | bus.m0_ready);
  assign w_acc        = bus.s_valid & bus.s_ready;
  assign w_last       = (r_cnt == c_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_cur_sel;
    w_mode_nxt  = r_mode;
    if (w_acc) begin
      if (r_state == S_IDLE) begin
        w_mode_nxt = mode;
      end
      if (w_last) begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
        w_sel_nxt   = w_burst_mode ? ~w_route : w_route;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_BW'(1);
        w_state_nxt = S_BURST;
        w_sel_nxt   = w_route;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cur_sel <= 1'b0;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_sel <= w_sel_nxt;
      r_mode    <= w_mode_nxt;
      r_done    <= w_acc & w_last;
    end
  end

  // A load always wins over a drain, so a same-cycle drain+load keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_valid <= 1'b0;
      r_m0_data  <= '0;
      r_m1_valid <= 1'b0;
      r_m1_data  <= '0;
    end else begin
      if (w_acc && !w_route) begin
        r_m0_valid <= 1'b1;
        r_m0_data  <= bus.s_data;
      end else if (bus.m0_ready) begin
        r_m0_valid <= 1'b0;
      end
      if (w_acc && w_route) begin
        r_m1_valid <= 1'b1;
        r_m1_data  <= bus.s_data;
      end else if (bus.m1_ready) begin
        r_m1_valid <= 1'b0;
      end
    end
  end

  assign bus.m0_valid = r_m0_valid;
  assign bus.m0_data  = r_m0_data;
  assign bus.m1_valid = r_m1_valid;
  assign bus.m1_data  = r_m1_data;
  assign cur_sel      = r_cur_sel;
  assign burst_done   = r_done;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (stats_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc && !w_route && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_acc &&  w_route && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1x2.sv
// Bench for stream_demux_1x2 (BURST_LEN=4): queue-based reference model plus
// directed scenarios; stats checks compile in when DEMUX_STATS_EN is defined.
`timescale 1ns/1ps
`default_nettype none

module tb_stream_demux_1x2;
  localparam int DW = 8;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic Sel = 1'b0;
  logic cur_sel, burst_done;

  always #5 clk = ~clk;

  stream_demux_1x2_if #(.In_d_W(DW)) bus ();

`ifdef DEMUX_STATS_EN
  localparam int CNT_W = 2;
  logic stats_clr = 1'b0;
  logic [CNT_W-1:0] cnt0, cnt1;
  int e_c0, e_c1;
`endif

  stream_demux_1x2 #(
    .In_d_W(DW),
`ifdef DEMUX_STATS_EN
    .CNT_W(CNT_W),
`endif
    .BURST_LEN(BL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .Sel(Sel),
    .bus(bus),
`ifdef DEMUX_STATS_EN
    .stats_clr(stats_clr),
    .cnt0(cnt0),
    .cnt1(cnt1),
`endif
    .cur_sel(cur_sel),
    .burst_done(burst_done)
  );

  int checks = 0;
  int errors = 0;

  // model state: what each branch register must hold, position in burst, route
  logic [7:0] q0[$], q1[$];
  int   pos;
  logic e_sel, e_bm, e_done;
  // observed output handshakes, for the directed literal checks
  logic [7:0] got0[$], got1[$];
  int   done_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string nm, input logic [7:0] g[$], input logic [7:0] e[$]);
    chk({nm, "_len"}, g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++)
      chk(nm, {24'b0, g[i]}, {24'b0, e[i]});
  endtask

  // Compare + model step on the falling edge, when all inputs are stable.
  always @(negedge clk) begin
    logic r, er, acc;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      pos = 0; e_sel = 1'b0; e_bm = 1'b0; e_done = 1'b0;
`ifdef DEMUX_STATS_EN
      e_c0 = 0; e_c1 = 0;
`endif
      chk("rst_m0_data", {24'b0, bus.m0_data}, 32'h0);
      chk("rst_m1_data", {24'b0, bus.m1_data}, 32'h0);
    end
    r  = (pos == 0 && !mode) ? Sel : e_sel;
    er = r ? (q1.size() == 0 || bus.m1_ready) : (q0.size() == 0 || bus.m0_ready);
    chk("m0_valid", bus.m0_valid, q0.size() != 0);
    if (q0.size() != 0) chk("m0_data", {24'b0, bus.m0_data}, {24'b0, q0[0]});
    chk("m1_valid", bus.m1_valid, q1.size() != 0);
    if (q1.size() != 0) chk("m1_data", {24'b0, bus.m1_data}, {24'b0, q1[0]});
    chk("s_ready", bus.s_ready, er);
    chk("cur_sel", cur_sel, e_sel);
    chk("burst_done", burst_done, e_done);
`ifdef DEMUX_STATS_EN
    chk("cnt0", cnt0, e_c0);
    chk("cnt1", cnt1, e_c1);
`endif
    if (rst_n) begin
      if (bus.m0_valid && bus.m0_ready) got0.push_back(bus.m0_data);
      if (bus.m1_valid && bus.m1_ready) got1.push_back(bus.m1_data);
      if (burst_done) done_cnt++;
      if (q0.size() != 0 && bus.m0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && bus.m1_ready) void'(q1.pop_front());
      acc    = bus.s_valid && er;
      e_done = 1'b0;
      if (acc) begin
        if (r) q1.push_back(bus.s_data);
        else   q0.push_back(bus.s_data);
`ifdef DEMUX_STATS_EN
        if (r && e_c1 < 3) e_c1++;
        if (!r && e_c0 < 3) e_c0++;
`endif
        if (pos == 0) e_bm = mode;
        pos++;
        if (pos == BL) begin
          pos = 0;
          e_done = 1'b1;
          e_sel = e_bm ? ~r : r;
        end else begin
          e_sel = r;
        end
      end
`ifdef DEMUX_STATS_EN
      if (stats_clr) begin e_c0 = 0; e_c1 = 0; end
`endif
    end
  end

  // Present one beat and hold it until accepted; leaves s_valid high.
  task automatic send(input logic [7:0] d);
    int w;
    logic a;
    w = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    do begin
      @(negedge clk);
      a = bus.s_ready;
      @(posedge clk); #1;
      w++;
    end while (!a && w < 40);
    chk("send_accept", {31'b0, a}, 32'h1);
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [7:0] e[$];
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus.m0_ready = 1'b1; bus.m1_ready = 1'b1;
    done_cnt = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("init_m0_valid", bus.m0_valid, 1'b0);
    chk("init_m1_valid", bus.m1_valid, 1'b0);
    chk("init_cur_sel", cur_sel, 1'b0);
    chk("init_s_ready", bus.s_ready, 1'b1);
    @(posedge clk); #1;

    // manual burst to branch 1, Sel wiggled mid-burst
    got0.delete(); got1.delete(); done_cnt = 0;
    mode = 1'b0; Sel = 1'b1;
    send(8'h11); Sel = 1'b0;
    send(8'h12); Sel = 1'b1;
    send(8'h13); Sel = 1'b0;
    send(8'h14);
    idle(4);
    e = '{8'h11, 8'h12, 8'h13, 8'h14};
    chk_q("t2_m1", got1, e);
    chk("t2_m0_cnt", got0.size(), 0);
    chk("t2_done", done_cnt, 1);
    chk("t2_cur_sel", cur_sel, 1'b1);

    // mid-stream asynchronous reset with beats held
    mode = 1'b1; bus.m0_ready = 1'b0; bus.m1_ready = 1'b0;
    send(8'h55);
    bus.s_data = 8'h56;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_m0_valid", bus.m0_valid, 1'b0);
    chk("rst_m1_valid", bus.m1_valid, 1'b0);
    chk("rst_m1_data0", {24'b0, bus.m1_data}, 32'h0);
    chk("rst_cur_sel", cur_sel, 1'b0);
    chk("rst_burst_done", burst_done, 1'b0);
    bus.s_valid = 1'b0; bus.m0_ready = 1'b1; bus.m1_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1'b1);
    @(posedge clk); #1;

    // auto ping-pong, three bursts
    got0.delete(); got1.delete(); done_cnt = 0;
    mode = 1'b1;
    for (int i = 1; i <= 12; i++) send(8'(i));
    idle(4);
    e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    chk_q("t3_m0", got0, e);
    e = '{8'h05, 8'h06, 8'h07, 8'h08};
    chk_q("t3_m1", got1, e);
    chk("t3_done", done_cnt, 3);

    // backpressure on branch 0
    got0.delete(); got1.delete();
    mode = 1'b0; Sel = 1'b0; bus.m0_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'h21 + 8'(i));
        bus.s_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t4_stall_s_ready", bus.s_ready, 1'b0);
        chk("t4_held", {24'b0, bus.m0_data}, 32'h21);
        repeat (3) @(posedge clk);
        #1 bus.m0_ready = 1'b1;
      end
    join
    idle(3);
    e = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    chk_q("t4_m0", got0, e);

    // unrouted branch keeps its held beat
    got0.delete(); got1.delete();
    Sel = 1'b1; bus.m1_ready = 1'b1;
    send(8'hA7); send(8'hA8); send(8'hA9); send(8'hAA);
    bus.s_valid = 1'b0; bus.m1_ready = 1'b0; Sel = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i));
    idle(3);
    @(negedge clk);
    chk("t5_m1_valid", bus.m1_valid, 1'b1);
    chk("t5_m1_data", {24'b0, bus.m1_data}, 32'hAA);
    e = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    chk_q("t5_m0", got0, e);
    @(posedge clk); #1 bus.m1_ready = 1'b1;
    idle(3);
    e = '{8'hA7, 8'hA8, 8'hA9, 8'hAA};
    chk_q("t5_m1", got1, e);

`ifdef DEMUX_STATS_EN
    // saturating counters and clear
    stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    Sel = 1'b0;
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i));
    idle(2);
    @(negedge clk);
    chk("t6_cnt0_sat", {30'b0, cnt0}, 32'h3);
    chk("t6_cnt1", {30'b0, cnt1}, 32'h0);
    @(posedge clk); #1 stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    @(negedge clk);
    chk("t6_cnt0_clr", {30'b0, cnt0}, 32'h0);
    @(posedge clk); #1;
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
